// File: rtl/blackjack_pkg.sv
// Shared blackjack datapath definitions: owner indices, card width and the
// deck access arbiter state encoding.
package blackjack_pkg;

    localparam int OWNER_HOUSE  = 0;
    localparam int OWNER_PLAYER = 1;
    localparam int CARD_W_DEF   = 4;

    localparam logic [2:0] ENC_IDLE       = 3'd0;
    localparam logic [2:0] ENC_ISSUE      = 3'd1;
    localparam logic [2:0] ENC_WAIT_CARD  = 3'd2;
    localparam logic [2:0] ENC_WAIT_ADDER = 3'd3;
    localparam logic [2:0] ENC_ADD        = 3'd4;
    localparam logic [2:0] ENC_SETTLE     = 3'd5;
    localparam logic [2:0] ENC_WAIT_SUM   = 3'd6;
    localparam logic [2:0] ENC_DONE       = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE       = ENC_IDLE,
        S_ISSUE      = ENC_ISSUE,
        S_WAIT_CARD  = ENC_WAIT_CARD,
        S_WAIT_ADDER = ENC_WAIT_ADDER,
        S_ADD        = ENC_ADD,
        S_SETTLE     = ENC_SETTLE,
        S_WAIT_SUM   = ENC_WAIT_SUM,
        S_DONE       = ENC_DONE
    } arb_state_t;

endpackage

// File: rtl/deck_access_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between house and player. On a tie the side
// that did not win last time is chosen.
module rr_arbiter2
    import blackjack_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // i_last_grant is 1 when the player owned the last completed transaction
    always_comb begin
        o_grant = 2'b00;
        if (i_req[OWNER_HOUSE] && (!i_req[OWNER_PLAYER] || i_last_grant)) begin
            o_grant[OWNER_HOUSE] = 1'b1;
        end else if (i_req[OWNER_PLAYER]) begin
            o_grant[OWNER_PLAYER] = 1'b1;
        end
    end

endmodule

// File: rtl/deck_access_arbiter.sv
// Shares the deck card source and hand adder between house and player,
// sequencing fetch -> latch -> add -> settle -> done with a wait timeout.
//
// state      | meaning
// IDLE       | no owner; arbitrate when deck is usable
// ISSUE      | pulse start_card to the deck
// WAIT_CARD  | wait for card_ready, then latch the card
// WAIT_ADDER | wait for the adder to be idle
// ADD        | pulse add_valid with the latched card
// SETTLE     | dead cycle while the adder drops ready
// WAIT_SUM   | wait for the sum to settle
// DONE       | pulse done to the owner, release grant
module deck_access_arbiter
    import blackjack_pkg::*;
#(
    parameter int CARD_W         = CARD_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        i_req,
    output logic [1:0]        o_grant,
    output logic [1:0]        o_done,
    output logic              o_timeout_err,
    output logic              o_busy,
    input  logic              i_shuffle_ready,
    input  logic              i_shuffling,
    output logic              o_start_card,
    input  logic              i_card_ready,
    input  logic [CARD_W-1:0] i_card_value,
    input  logic              i_adder_ready,
    output logic              o_add_valid,
    output logic [CARD_W-1:0] o_add_value,
    output logic              o_sum_select
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [1:0]        r_grant;
    logic              r_sum_select;
    logic [CARD_W-1:0] r_add_value;
    logic              r_last_grant;
    logic [TW-1:0]     r_timer;
    logic              r_timeout_err;

    logic [1:0]        w_arb_grant;
    logic              w_take_grant;
    logic              w_latch;
    logic              w_abort;
    logic              w_timer_clr;
    logic              w_timer_inc;
    logic              w_timer_end;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant)
    );

    assign w_timer_end = (r_timer == TMAX);

    always_comb begin
        w_next_state = r_state;
        w_take_grant = 1'b0;
        w_latch      = 1'b0;
        w_abort      = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((|i_req) && i_shuffle_ready && !i_shuffling) begin
                    w_take_grant = 1'b1;
                    w_next_state = S_ISSUE;
                    w_timer_clr  = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_CARD;
                w_timer_clr  = 1'b1;
            end
            // A shuffle kills the transaction outright; a ready on the
            // final timer cycle still completes the step.
            S_WAIT_CARD: begin
                if (i_shuffling) begin
                    w_abort = 1'b1;
                end else if (i_card_ready) begin
                    w_latch      = 1'b1;
                    w_next_state = S_WAIT_ADDER;
                    w_timer_clr  = 1'b1;
                end else if (w_timer_end) begin
                    w_abort = 1'b1;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_WAIT_ADDER: begin
                if (i_shuffling) begin
                    w_abort = 1'b1;
                end else if (i_adder_ready) begin
                    w_next_state = S_ADD;
                    w_timer_clr  = 1'b1;
                end else if (w_timer_end) begin
                    w_abort = 1'b1;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_ADD: begin
                w_next_state = S_SETTLE;
                w_timer_clr  = 1'b1;
            end
            S_SETTLE: begin
                w_next_state = S_WAIT_SUM;
                w_timer_clr  = 1'b1;
            end
            S_WAIT_SUM: begin
                if (i_shuffling) begin
                    w_abort = 1'b1;
                end else if (i_adder_ready) begin
                    w_next_state = S_DONE;
                    w_timer_clr  = 1'b1;
                end else if (w_timer_end) begin
                    w_abort = 1'b1;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_timer_clr  = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
                w_timer_clr  = 1'b1;
            end
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
            w_timer_clr  = 1'b1;
            w_timer_inc  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_sum_select  <= 1'b0;
            r_add_value   <= '0;
            r_last_grant  <= 1'b1;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timeout_err <= w_abort;
            if (w_take_grant) begin
                r_grant      <= w_arb_grant;
                r_sum_select <= w_arb_grant[OWNER_PLAYER];
            end else if (w_abort || (r_state == S_DONE)) begin
                r_grant <= 2'b00;
            end
            // An aborted transaction never counts as a win for round-robin
            if (r_state == S_DONE) begin
                r_last_grant <= r_grant[OWNER_PLAYER];
            end
            if (w_latch) begin
                r_add_value <= i_card_value;
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_done        = (r_state == S_DONE) ? r_grant : 2'b00;
    assign o_timeout_err = r_timeout_err;
    assign o_busy        = (r_state != S_IDLE);
    assign o_start_card  = (r_state == S_ISSUE);
    assign o_add_valid   = (r_state == S_ADD);
    assign o_add_value   = r_add_value;
    assign o_sum_select  = r_sum_select;

endmodule
